mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Execute-stage issue and retire controller for RV32M multiply instructions. Sits directly upstream of `multiplier_iterative`. It decodes MUL/MULH/MULHSU/MULHU from funct3, latches the operands and destination, and pulses `startM`. It stalls the pipeline front end until the multiplier's `done`, then hands the result to the MEM-stage pipeline register as a one-cycle writeback. It also covers flushes and a hung multiplier.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum number of WAIT cycles before an abort.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: EX stage holds a valid instruction.
- `ex_is_mext` in 1: instruction has opcode OP and funct7 = 0000001.
- `ex_funct3` in 3: funct3 of the EX instruction.
- `ex_rs1_val`, `ex_rs2_val` in 32: forwarded source operands.
- `ex_rd` in 5: destination register.
- `flush` in 1: kill the EX instruction and any in-flight multiply.
- `stall_ex` out 1: freeze IF/ID/EX (combinational).
- `startM` out 1: start pulse to the multiplier.
- `mul_opcode` out 2: operation code to the multiplier.
- `operand1`, `operand2` out 32: operands to the multiplier.
- `done` in 1: multiplier completion pulse.
- `result_multiply` in 32: multiplier result, valid while `done` = 1.
- `wb_valid` out 1: one-cycle retire strobe.
- `wb_rd` out 5: retiring destination register.
- `wb_data` out 32: retiring result.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: sticky flag, cleared only by `rst`.

## Operation
Accept condition: `acc = ex_valid & ex_is_mext & ~ex_funct3[2] & ~flush`. funct3[2] = 1 (divide/remainder) is ignored; the divider owns those instructions.

Opcode map: funct3 000→00 MUL, 001→01 MULH, 010→10 MULHSU, 011→11 MULHU.

States:
- **IDLE**
  - On `acc`: latch `operand1`/`operand2`/`mul_opcode`/rd, go to ISSUE.
- **ISSUE**
  - `startM` = 1 for exactly this cycle; clear the timeout counter.
  - Go to WAIT, or to DRAIN if `flush`.
- **WAIT**
  - On `done`: capture `result_multiply` into `wb_data`, go to RESP.
  - Else on `flush`: go to DRAIN.
  - Else on counter = `TIMEOUT_CYCLES`-1: set `timeout_err`, go to IDLE with no writeback.
  - Otherwise increment the counter.
  - `done` takes priority over `flush` in the same cycle: the result retires.
- **RESP**
  - `wb_valid` = 1 with `wb_rd` = latched rd.
  - Always return to IDLE; never accept in RESP.
- **DRAIN**
  - The multiplier cannot be aborted, so this state waits for `done` and discards the result.
  - Go to IDLE on `done` or timeout (timeout sets `timeout_err`).

Stall: `stall_ex = (IDLE & acc) | ISSUE | WAIT | (DRAIN & acc)`. In RESP `stall_ex` = 0, so the completed instruction leaves EX on that edge.

Holding rules:
- `operand1`, `operand2` and `mul_opcode` are registered and held stable from ISSUE until the next accept.
- `wb_data` and `wb_rd` hold their last values when `wb_valid` = 0.
- rd = x0 is executed normally; the register file discards the write.

Reset values: all outputs 0, state IDLE, counter 0. `rst` mid-operation returns to IDLE with no `wb_valid`. The multiplier is reset by the same `rst`.

## Timing
- Accept in cycle Ta; `startM` in Ta+1.
- The controller is latency-agnostic and waits only on `done`. With the production multiplier, `done` arrives at Ta+35, so RESP/`wb_valid` falls in Ta+36.
- `stall_ex` is high from Ta to Ta+35 inclusive: 36 stall cycles.
- Back-to-back multiplies: the second is accepted at Ta+37, the cycle after RESP.
- `startM` is never asserted unless the state was IDLE, so the multiplier is guaranteed idle when it samples `startM`.

## Structure
- Shared package `m_ext_pkg`:
  - enum `mul_op_e` (MUL/MULH/MULHSU/MULHU = 00/01/10/11);
  - funct3 constants;
  - `FUNCT7_MEXT` = 7'b0000001;
  - enum `mic_state_e` {IDLE, ISSUE, WAIT, RESP, DRAIN}.
- Single module with no sub-module. The timeout counter is `$clog2(TIMEOUT_CYCLES)` bits and inline.

## Test plan
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF (funct3 011), multiplier model with 34-cycle latency → `startM` at Ta+1, 36 stall cycles, `wb_valid` at Ta+36 with `wb_data` 0xFFFFFFFE and the correct `wb_rd`.
- MUL: 7 × 6 immediately followed by a second MUL 3 × 5 → two `wb_valid` pulses carrying 42 then 15; second `startM` at Ta+38; exactly one `startM` per instruction.
- `flush` in WAIT cycle 10 → DRAIN, `stall_ex` drops, no `wb_valid`. A new MUL presented during DRAIN stalls until `done`, then is accepted and retires correctly.
- funct3 = 100 (DIV) with `ex_is_mext` = 1 → no `startM`, `stall_ex` 0, state stays IDLE. `done` and `flush` asserted together in WAIT → the result retires.
- Model that never asserts `done`, `TIMEOUT_CYCLES` = 8 → `timeout_err` set after 8 WAIT cycles, return to IDLE, no `wb_valid`. `rst` asserted mid-WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared RV32M decode definitions: funct3/funct7 encodings, multiplier opcodes
// and the issue-controller state encoding.
package m_ext_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } mic_state_e;

  // Divide/remainder encodings never reach this: callers gate on funct3[2].
  function automatic mul_op_e decode_mul_op(input logic [2:0] funct3);
    case (funct3)
      F3_MUL:    return MUL;
      F3_MULH:   return MULH;
      F3_MULHSU: return MULHSU;
      default:   return MULHU;
    endcase
  endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// EX-stage issue/retire controller for RV32M multiplies: latches operands,
// starts the iterative multiplier, stalls the front end and retires the result.
module mul_issue_ctrl
  import m_ext_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_mext,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1_val,
  input  logic [31:0] ex_rs2_val,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        stall_ex,
  output logic        startM,
  output logic [1:0]  mul_opcode,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  input  logic        done,
  input  logic [31:0] result_multiply,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mic_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       rd_q;
  logic             acc;
  logic             cnt_expired;

  assign acc         = ex_valid & ex_is_mext & ~ex_funct3[2] & ~flush;
  assign cnt_expired = (wait_cnt == CNT_LAST);
  assign busy        = (state != IDLE);

  // In DRAIN a new multiply must wait until the old one finishes, otherwise it
  // would be issued into a multiplier that is still busy.
  always_comb begin
    stall_ex = 1'b0;
    case (state)
      IDLE:    stall_ex = acc;
      ISSUE:   stall_ex = 1'b1;
      WAIT:    stall_ex = 1'b1;
      DRAIN:   stall_ex = acc;
      default: stall_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rd_q        <= '0;
      startM      <= 1'b0;
      mul_opcode  <= '0;
      operand1    <= '0;
      operand2    <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: strobes default low here so each is a single-cycle pulse; the
      // case below only raises them on the transition that owns them.
      startM   <= 1'b0;
      wb_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (acc) begin
            operand1   <= ex_rs1_val;
            operand2   <= ex_rs2_val;
            mul_opcode <= decode_mul_op(ex_funct3);
            rd_q       <= ex_rd;
            startM     <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          wait_cnt <= '0;
          state    <= flush ? DRAIN : WAIT;
        end

        // A completion in the same cycle as a flush still retires.
        WAIT: begin
          if (done) begin
            wb_data  <= result_multiply;
            wb_rd    <= rd_q;
            wb_valid <= 1'b1;
            state    <= RESP;
          end else if (flush) begin
            state <= DRAIN;
          end else if (cnt_expired) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: state <= IDLE;

        // The multiplier cannot be cancelled; swallow its result. The counter
        // keeps running from WAIT so the whole operation stays bounded.
        DRAIN: begin
          if (done) begin
            state <= IDLE;
          end else if (cnt_expired) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: vector table, hand-written corner
// sequences and randomized instructions against a transaction-level model.
module tb_mul_issue_ctrl;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_is_mext = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_rs1_val = '0;
  logic [31:0] ex_rs2_val = '0;
  logic [4:0]  ex_rd = '0;
  logic        flush = 1'b0;
  logic        done;
  logic [31:0] result_multiply;

  logic        stall_ex, startM, wb_valid, busy, timeout_err;
  logic [1:0]  mul_opcode;
  logic [31:0] operand1, operand2, wb_data;
  logic [4:0]  wb_rd;

  // Second instance with a short timeout and a multiplier that never answers.
  logic        to_valid = 1'b0;
  logic        to_done = 1'b0;
  logic [31:0] to_result = '0;
  logic        to_stall_ex, to_startM, to_wb_valid, to_busy, to_timeout_err;
  logic [1:0]  to_mul_opcode;
  logic [31:0] to_operand1, to_operand2, to_wb_data;
  logic [4:0]  to_wb_rd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_mext(ex_is_mext),
    .ex_funct3(ex_funct3), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .flush(flush), .stall_ex(stall_ex), .startM(startM),
    .mul_opcode(mul_opcode), .operand1(operand1), .operand2(operand2),
    .done(done), .result_multiply(result_multiply), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .timeout_err(timeout_err)
  );

  mul_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst(rst), .ex_valid(to_valid), .ex_is_mext(ex_is_mext),
    .ex_funct3(ex_funct3), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .flush(flush), .stall_ex(to_stall_ex), .startM(to_startM),
    .mul_opcode(to_mul_opcode), .operand1(to_operand1), .operand2(to_operand2),
    .done(to_done), .result_multiply(to_result), .wb_valid(to_wb_valid),
    .wb_rd(to_wb_rd), .wb_data(to_wb_data), .busy(to_busy), .timeout_err(to_timeout_err)
  );

  // RV32M multiply semantics from the ISA: sign/zero extend to 64 bits, multiply.
  function automatic logic [31:0] mul_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
    xb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: done pulses LAT cycles after the startM cycle; the result
  // bus carries junk outside the done cycle.
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0; m_res <= '0;
      done <= 1'b0; result_multiply <= '0;
    end else begin
      done <= 1'b0;
      result_multiply <= 32'hDEAD_BEEF;
      if (startM) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT - 1;
        m_res  <= mul_ref({1'b0, mul_opcode}, operand1, operand2);
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          done <= 1'b1;
          result_multiply <= m_res;
          m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents one instruction in EX and holds it until stall_ex releases it.
  task automatic run_instr(input logic v, input logic m, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           output int stalls, output int starts, output int start_off,
                           output int wbs, output int fin_wb, output logic [31:0] fdata,
                           output logic [4:0] frd, output int start_cyc);
    int k;
    ex_valid = v; ex_is_mext = m; ex_funct3 = f3;
    ex_rs1_val = a; ex_rs2_val = b; ex_rd = rd;
    stalls = 0; starts = 0; start_off = -1; wbs = 0; start_cyc = -1; k = 0;
    #1;
    while (stall_ex && k < 200) begin
      if (startM) begin
        starts++;
        if (start_off < 0) begin start_off = k; start_cyc = cyc; end
      end
      if (wb_valid) wbs++;
      stalls++;
      step();
      k++;
    end
    if (k >= 200) begin
      tests++; fails++;
      $display("FAIL stall_bound: stall_ex still high after %0d cycles, expected release", k);
    end
    if (startM) starts++;
    if (wb_valid) wbs++;
    fin_wb = int'(wb_valid);
    fdata  = wb_data;
    frd    = wb_rd;
    step();
    ex_valid = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic        m;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        exp_wb;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int stalls, starts, soff, wbs, fwb, scyc;
    int sc[13];
    logic [31:0] fdata;
    logic [4:0]  frd;
    int wbc, stc;
    logic done_seen;

    vecs[0]  = '{1'b1, 1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  1'b1, 32'hFFFF_FFFE};
    vecs[1]  = '{1'b1, 1'b1, 3'b000, 32'd7,         32'd6,         5'd1,  1'b1, 32'd42};
    vecs[2]  = '{1'b1, 1'b1, 3'b000, 32'd3,         32'd5,         5'd2,  1'b1, 32'd15};
    vecs[3]  = '{1'b1, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'd1,         5'd3,  1'b1, 32'hFFFF_FFFF};
    vecs[4]  = '{1'b1, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  1'b1, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b1, 1'b1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  1'b1, 32'h4000_0000};
    vecs[6]  = '{1'b1, 1'b1, 3'b000, 32'd2,         32'd3,         5'd0,  1'b1, 32'd6};
    vecs[7]  = '{1'b1, 1'b1, 3'b100, 32'd100,       32'd7,         5'd9,  1'b0, 32'd0};
    vecs[8]  = '{1'b1, 1'b1, 3'b111, 32'd100,       32'd7,         5'd9,  1'b0, 32'd0};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'd4,         32'd4,         5'd9,  1'b0, 32'd0};
    vecs[10] = '{1'b0, 1'b1, 3'b000, 32'd4,         32'd4,         5'd9,  1'b0, 32'd0};
    vecs[11] = '{1'b1, 1'b1, 3'b011, 32'h8000_0000, 32'd2,         5'd10, 1'b1, 32'd1};
    vecs[12] = '{1'b1, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'd1};

    // Reset state
    step();
    step();
    check("rst_stall_ex", stall_ex, 0);
    check("rst_startM", startM, 0);
    check("rst_busy", busy, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_operand1", operand1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      run_instr(vecs[i].v, vecs[i].m, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                stalls, starts, soff, wbs, fwb, fdata, frd, scyc);
      sc[i] = scyc;
      check($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_wb ? 36 : 0);
      check($sformatf("vec%0d_starts", i), starts, vecs[i].exp_wb ? 1 : 0);
      check($sformatf("vec%0d_wb_count", i), wbs, vecs[i].exp_wb ? 1 : 0);
      check($sformatf("vec%0d_wb_final", i), fwb, vecs[i].exp_wb ? 1 : 0);
      if (vecs[i].exp_wb) begin
        check($sformatf("vec%0d_start_offset", i), soff, 1);
        check($sformatf("vec%0d_wb_data", i), fdata, vecs[i].exp_data);
        check($sformatf("vec%0d_wb_rd", i), frd, vecs[i].rd);
      end
    end
    check("b2b_start_gap", sc[2] - sc[1], 37);

    // Flush in WAIT cycle 10, then a new multiply waits out the drain
    ex_valid = 1'b1; ex_is_mext = 1'b1; ex_funct3 = 3'b000;
    ex_rs1_val = 32'd9; ex_rs2_val = 32'd9; ex_rd = 5'd7;
    wbc = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 11) flush = 1'b1;
      #1;
      if (wb_valid) wbc++;
      step();
    end
    flush = 1'b0; ex_valid = 1'b0;
    #1;
    check("drain_busy", busy, 1);
    check("drain_stall_ex", stall_ex, 0);
    check("drain_wb_valid", wb_valid | (wbc != 0), 0);
    step();
    run_instr(1'b1, 1'b1, 3'b000, 32'd5, 32'd11, 5'd8, stalls, starts, soff, wbs, fwb, fdata, frd, scyc);
    check("drain_new_stalls", stalls, 59);
    check("drain_new_wb_count", wbs, 1);
    check("drain_new_starts", starts, 1);
    check("drain_new_wb_data", fdata, 32'd55);
    check("drain_new_wb_rd", frd, 5'd8);

    // done and flush in the same WAIT cycle: the result still retires
    ex_valid = 1'b1; ex_is_mext = 1'b1; ex_funct3 = 3'b000;
    ex_rs1_val = 32'h1234_5678; ex_rs2_val = 32'h10; ex_rd = 5'd9;
    done_seen = 1'b0;
    for (int k = 0; k < 60 && !done_seen; k++) begin
      #1;
      if (done) begin
        done_seen = 1'b1;
        flush = 1'b1;
      end
      step();
    end
    flush = 1'b0; ex_valid = 1'b0;
    #1;
    check("done_flush_seen", done_seen, 1);
    check("done_flush_wb_valid", wb_valid, 1);
    check("done_flush_wb_data", wb_data, 32'h2345_6780);
    check("done_flush_wb_rd", wb_rd, 5'd9);
    step();
    step();

    // Timeout on the instance whose multiplier never answers
    ex_is_mext = 1'b1; ex_funct3 = 3'b000; ex_rs1_val = 32'd1; ex_rs2_val = 32'd1; ex_rd = 5'd3;
    to_valid = 1'b1;
    wbc = 0; stc = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (to_wb_valid) wbc++;
      if (to_startM) stc++;
      if (k == 0) check("to_accept_stall", to_stall_ex, 1);
      if (k == 1) check("to_startM", to_startM, 1);
      if (k == 9) begin
        check("to_err_before", to_timeout_err, 0);
        check("to_busy_last_wait", to_busy, 1);
      end
      if (k == 10) begin
        check("to_err_set", to_timeout_err, 1);
        check("to_busy_idle", to_busy, 0);
      end
      step();
      to_valid = 1'b0;
    end
    check("to_no_wb", wbc, 0);
    check("to_one_start", stc, 1);
    check("to_err_sticky", to_timeout_err, 1);

    // Asynchronous reset in the middle of WAIT
    ex_valid = 1'b1; ex_funct3 = 3'b001; ex_rs1_val = 32'h55; ex_rs2_val = 32'h77; ex_rd = 5'd12;
    for (int k = 0; k < 8; k++) step();
    ex_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_stall_ex", stall_ex, 0);
    check("mrst_startM", startM, 0);
    check("mrst_operands", {operand1, operand2}, 0);
    check("mrst_opcode", mul_opcode, 0);
    check("mrst_wb", {wb_valid, wb_rd, wb_data}, 0);
    check("mrst_to_err", to_timeout_err, 0);
    step();
    rst = 1'b0;
    wbc = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (wb_valid) wbc++;
    end
    check("mrst_no_wb", wbc, 0);

    // Randomized instructions against the ISA model
    for (int i = 0; i < 24; i++) begin
      logic v, m, is_mul;
      logic [2:0] f3;
      logic [31:0] a, b;
      logic [4:0] rd;
      v  = ($urandom_range(0, 9) < 9);
      m  = ($urandom_range(0, 9) < 8);
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rd = 5'($urandom_range(0, 31));
      is_mul = v & m & ~f3[2];
      run_instr(v, m, f3, a, b, rd, stalls, starts, soff, wbs, fwb, fdata, frd, scyc);
      check($sformatf("rnd%0d_stalls", i), stalls, is_mul ? 36 : 0);
      check($sformatf("rnd%0d_wb", i), fwb, is_mul ? 1 : 0);
      if (is_mul) begin
        check($sformatf("rnd%0d_data_f3_%0d", i, f3), fdata, mul_ref(f3, a, b));
        check($sformatf("rnd%0d_rd", i), frd, rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
